// File: rtl/tx_channel_scheduler_if.sv
// Stream bundle for tx_channel_scheduler: three source channels in,
// one tagged stream out.
interface tx_channel_scheduler_if #(
  parameter int DATA_W = 128
);
  logic [2:0]          s_tvalid;
  logic [3*DATA_W-1:0] s_tdata;
  logic [2:0]          s_tready;
  logic                m_tvalid;
  logic [DATA_W-1:0]   m_tdata;
  logic [1:0]          m_tid;
  logic                m_tlast;
  logic                m_tready;

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tid, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tid, m_tlast
  );
endinterface

// File: rtl/tx_channel_scheduler.sv
// Round-robin burst scheduler: three channels onto one output stream.
// Define TX_SCHED_STATS_EN to build the per-channel accepted-beat counters.
module tx_channel_scheduler #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  tx_channel_scheduler_if.slave bus,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [3*32-1:0]      stat_beats
);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         pick;
  logic [1:0]         c0, c1, c2;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               out_free;
  logic               accept;
  logic               at_last;
  logic               mv_q, ml_q;
  logic [DATA_W-1:0]  md_q;
  logic [1:0]         mid_q;

  function automatic logic [1:0] nxt(
    input logic [1:0] c
  );
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // search order starts one past the previous owner
  assign c0 = nxt(last_q);
  assign c1 = nxt(c0);
  assign c2 = nxt(c1);

  always_comb begin
    pick = c2;
    if (bus.s_tvalid[c0])
      pick = c0;
    else if (bus.s_tvalid[c1])
      pick = c1;
  end

  always_comb begin
    sel_valid = bus.s_tvalid[0];
    sel_data  = bus.s_tdata[0 +: DATA_W];
    unique case (gnt_q)
      2'd1: begin
        sel_valid = bus.s_tvalid[1];
        sel_data  = bus.s_tdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_valid = bus.s_tvalid[2];
        sel_data  = bus.s_tdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == GRANT);
  assign grant    = busy ? gnt_q : 2'd3;
  assign out_free = !mv_q || bus.m_tready;
  assign accept   = busy && sel_valid && out_free;
  assign at_last  = (cnt_q == LAST_CNT);

  assign bus.s_tready =
    (busy && out_free) ? (3'b001 << gnt_q) : 3'b000;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.s_tvalid) begin
          state_d = GRANT;
          gnt_d   = pick;
        end
      end
      GRANT: begin
        // a stalled output with valid still high keeps the grant
        if ((accept && at_last) || !sel_valid) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
      mid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      if (state_q == IDLE)
        cnt_q <= '0;
      else if (accept)
        cnt_q <= cnt_q + CNT_W'(1);
      if (accept) begin
        mv_q  <= 1'b1;
        md_q  <= sel_data;
        mid_q <= gnt_q;
        ml_q  <= at_last;
      end else if (bus.m_tready) begin
        mv_q <= 1'b0;
        ml_q <= 1'b0;
      end
    end
  end

  assign bus.m_tvalid = mv_q;
  assign bus.m_tdata  = md_q;
  assign bus.m_tid    = mid_q;
  assign bus.m_tlast  = ml_q;

`ifdef TX_SCHED_STATS_EN
  for (genvar n = 0; n < 3; n++) begin : g_stat
    logic [31:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (accept && gnt_q == 2'(n))
        cnt <= cnt + 32'd1;
    end
    assign stat_beats[n*32 +: 32] = cnt;
  end
`else
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_tx_channel_scheduler.sv
// Bench for tx_channel_scheduler: directed burst scenarios
// plus randomized traffic against a per-channel order model.
module tb_tx_channel_scheduler;
  localparam int DW = 128;
  localparam int BL = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant;
  logic        busy;
  logic [95:0] stat_beats;

  always #5 clock = ~clock;

  tx_channel_scheduler_if #(.DATA_W(DW)) bus ();

  tx_channel_scheduler #(
    .DATA_W(DW),
    .BURST_LEN(BL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .grant(grant),
    .busy(busy),
    .stat_beats(stat_beats)
  );

  typedef struct {
    int          tid;
    logic [DW-1:0] data;
    bit          last;
    int          cyc;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src_q[3][$];
  logic [DW-1:0] exp_q[3][$];
  bit            en[3];
  int            rmode = 0;
  beat_t         blog[$];
  int            cyc = 0;
  int            outcnt[3];
  int            nstall = 0;

  task automatic check(
    input string      tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push(input int n, input int cnt);
    logic [DW-1:0] d;
    for (int k = 0; k < cnt; k++) begin
      d = rnd();
      src_q[n].push_back(d);
      exp_q[n].push_back(d);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 3; n++) begin
      bus.s_tvalid[n] = en[n] && (src_q[n].size() > 0);
      bus.s_tdata[n*DW +: DW] =
        (src_q[n].size() > 0) ? src_q[n][0] : '0;
    end
    case (rmode)
      1:       bus.m_tready = ~bus.m_tready;
      2:       bus.m_tready = 1'($urandom_range(0, 1));
      default: bus.m_tready = 1'b1;
    endcase
  endtask

  // source/sink model: sample at negedge, advance after posedge
  initial begin
    bit            fire[3];
    bit            pstall;
    logic [DW-1:0] pdata;
    logic [1:0]    ptid;
    logic          plast;
    int            t;
    int            avail;
    pstall = 0;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    forever begin
      @(negedge clock);
      cyc++;
      for (int n = 0; n < 3; n++) fire[n] = 0;
      if (!reset) begin
        if (pstall) begin
          nstall++;
          check("hold_valid", bus.m_tvalid, 1);
          check("hold_data", bus.m_tdata, pdata);
          check("hold_tid", bus.m_tid, ptid);
          check("hold_last", bus.m_tlast, plast);
        end
        if (bus.m_tvalid && bus.m_tready) begin
          t = int'(bus.m_tid);
          avail = (t <= 2) ? exp_q[t].size() : 0;
          check("beat_expected", avail > 0, 1);
          if (avail > 0) begin
            check("data", bus.m_tdata, exp_q[t].pop_front());
            outcnt[t]++;
          end
          blog.push_back('{t, bus.m_tdata, bus.m_tlast, cyc});
        end
        pstall = bus.m_tvalid && !bus.m_tready;
        pdata  = bus.m_tdata;
        ptid   = bus.m_tid;
        plast  = bus.m_tlast;
        for (int n = 0; n < 3; n++)
          fire[n] = bus.s_tvalid[n] && bus.s_tready[n];
      end else begin
        pstall = 0;
      end
      @(posedge clock);
      #1;
      if (!reset)
        for (int n = 0; n < 3; n++)
          if (fire[n] && src_q[n].size() > 0)
            void'(src_q[n].pop_front());
      drive();
    end
  end

  function automatic bit drained();
    for (int n = 0; n < 3; n++)
      if (src_q[n].size() != 0 || exp_q[n].size() != 0)
        return 0;
    return !bus.m_tvalid;
  endfunction

  task automatic wait_drain(input string tag, input int maxc);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clock);
      #1;
      done = drained();
    end
    check(tag, done, 1);
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_mvalid"}, bus.m_tvalid, 0);
    check({tag, "_mlast"}, bus.m_tlast, 0);
    check({tag, "_mtid"}, bus.m_tid, 0);
    check({tag, "_mdata"}, bus.m_tdata, 0);
    check({tag, "_grant"}, grant, 3);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sready"}, bus.s_tready, 0);
    check({tag, "_stats"}, stat_beats, 0);
  endtask

  initial begin
    int base;
    int i;
    bit hit;
    for (int n = 0; n < 3; n++) begin
      en[n] = 0;
      outcnt[n] = 0;
    end

    repeat (3) @(negedge clock);
    #1;
    check_rst_vals("por");
    reset = 1'b0;

    // all channels saturated: 9 bursts, rotation 0,1,2
    for (int n = 0; n < 3; n++) begin
      en[n] = 1;
      push(n, 3 * BL);
    end
    base = blog.size();
    wait_drain("rr_drain", 2000);
    check("rr_count", blog.size() - base, 9 * BL);
    if (blog.size() - base == 9 * BL) begin
      for (i = 0; i < 9 * BL; i++) begin
        check("rr_tid", blog[base+i].tid, (i / BL) % 3);
        check("rr_last", blog[base+i].last, (i % BL) == BL - 1);
        check("rr_gap", blog[base+i].cyc - blog[base].cyc,
              i + i / BL);
      end
    end
    check("rr_grant_idle", grant, 3);
    check("rr_busy_idle", busy, 0);
    for (int n = 0; n < 3; n++)
`ifdef TX_SCHED_STATS_EN
      check("stat_rr", stat_beats[n*32 +: 32], 3 * BL);
`else
      check("stat_off", stat_beats[n*32 +: 32], 0);
`endif

    // channel 1 alone for 40 beats: 16, 16, then 8 released
    en[0] = 0;
    en[2] = 0;
    push(1, 40);
    base = blog.size();
    wait_drain("solo_drain", 1000);
    check("solo_count", blog.size() - base, 40);
    if (blog.size() - base == 40) begin
      for (i = 0; i < 40; i++) begin
        check("solo_tid", blog[base+i].tid, 1);
        check("solo_last", blog[base+i].last,
              (i == 15) || (i == 31));
        check("solo_gap", blog[base+i].cyc - blog[base].cyc,
              i + i / BL);
      end
    end
    check("solo_grant", grant, 3);

    // channel 0 with a toggling sink
    en[1] = 0;
    en[0] = 1;
    rmode = 1;
    nstall = 0;
    push(0, 20);
    base = blog.size();
    wait_drain("tog_drain", 1000);
    check("tog_count", blog.size() - base, 20);
    if (blog.size() - base == 20) begin
      for (i = 0; i < 20; i++) begin
        check("tog_tid", blog[base+i].tid, 0);
        check("tog_last", blog[base+i].last, i == BL - 1);
      end
    end
    check("tog_stalls", nstall > 0, 1);

    // asynchronous reset on the fifth output beat
    rmode = 0;
    en[0] = 0;
    en[1] = 1;
    push(1, BL);
    base = blog.size();
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clock);
      #1;
      hit = (blog.size() - base >= 5);
    end
    check("rst_reach5", hit, 1);
    check("rst_pre_valid", bus.m_tvalid, 1);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_rst_vals("midrst");
    for (int n = 0; n < 3; n++) begin
      src_q[n].delete();
      exp_q[n].delete();
      en[n] = 0;
      outcnt[n] = 0;
    end
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    en[0] = 1;
    en[2] = 1;
    push(0, 4);
    push(2, 4);
    base = blog.size();
    wait_drain("post_drain", 500);
    check("post_count", blog.size() - base, 8);
    if (blog.size() - base == 8) begin
      check("post_first", blog[base].tid, 0);
      check("post_second", blog[base+4].tid, 2);
    end

    // randomized traffic and sink backpressure
    rmode = 2;
    for (int n = 0; n < 3; n++)
      push(n, $urandom_range(30, 60));
    hit = 0;
    for (int k = 0; k < 8000 && !hit; k++) begin
      @(negedge clock);
      #1;
      for (int n = 0; n < 3; n++)
        en[n] = ($urandom_range(0, 3) != 0);
      hit = drained();
    end
    check("rand_drain", hit, 1);
    rmode = 0;
    repeat (3) @(negedge clock);
    #1;
    check("rand_grant_idle", grant, 3);
    for (int n = 0; n < 3; n++)
`ifdef TX_SCHED_STATS_EN
      check("stat_rand", stat_beats[n*32 +: 32], outcnt[n]);
`else
      check("stat_rand_off", stat_beats[n*32 +: 32], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
